// File: rtl/synth_env_pkg.sv
// -----------------------------------------------------------------------------
// synth_env_pkg
// Shared definitions for the synth envelope / modulation blocks.
//   PH_IDLE..PH_RELEASE   : phase encoding as seen on the `phase` output
//   phase_e               : FSM state type built on that encoding
//   SETTLE_CYCLES_DEFAULT : default blanking window after a controller restart
//   maxl()                : full-scale level (2^width - 1) for a given width
// -----------------------------------------------------------------------------
package synth_env_pkg;

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_ATTACK  = 3'd1;
    localparam logic [2:0] PH_DECAY   = 3'd2;
    localparam logic [2:0] PH_SUSTAIN = 3'd3;
    localparam logic [2:0] PH_RELEASE = 3'd4;

    // The controller needs 3 cycles to reload its divider; one extra for margin.
    localparam int SETTLE_CYCLES_DEFAULT = 32'sd4;

    typedef enum logic [2:0] {
        ST_IDLE    = PH_IDLE,
        ST_ATTACK  = PH_ATTACK,
        ST_DECAY   = PH_DECAY,
        ST_SUSTAIN = PH_SUSTAIN,
        ST_RELEASE = PH_RELEASE
    } phase_e;

    function automatic int maxl(input int width);
        return (32'sd1 << width) - 32'sd1;
    endfunction

endpackage

// File: rtl/adsr_envelope_sequencer_if.sv
// -----------------------------------------------------------------------------
// adsr_envelope_sequencer_if
// Bundles the note/controller/level signals of the ADSR envelope sequencer.
//   master : host side - drives gate, lengths, sustain and the controller's
//            inc_pulse; observes controller commands and envelope outputs
//   slave  : the sequencer itself
// Signals: gate, attack_len, decay_len, release_len, sustain_level, inc_pulse,
//          ctrl_start, ctrl_max_out, ctrl_pulse_length, level, phase, active
// -----------------------------------------------------------------------------
interface adsr_envelope_sequencer_if #(
    parameter int WIDTH = 10
);
    logic             gate;
    logic [WIDTH-1:0] attack_len;
    logic [WIDTH-1:0] decay_len;
    logic [WIDTH-1:0] release_len;
    logic [WIDTH-1:0] sustain_level;
    logic             inc_pulse;
    logic             ctrl_start;
    logic [WIDTH-1:0] ctrl_max_out;
    logic [WIDTH-1:0] ctrl_pulse_length;
    logic [WIDTH-1:0] level;
    logic [2:0]       phase;
    logic             active;

    modport master (
        output gate, attack_len, decay_len, release_len, sustain_level, inc_pulse,
        input  ctrl_start, ctrl_max_out, ctrl_pulse_length, level, phase, active
    );

    modport slave (
        input  gate, attack_len, decay_len, release_len, sustain_level, inc_pulse,
        output ctrl_start, ctrl_max_out, ctrl_pulse_length, level, phase, active
    );
endinterface

// File: rtl/adsr_envelope_sequencer_gate_edge_detect.sv
// -----------------------------------------------------------------------------
// gate_edge_detect
// Registers a synchronous gate and flags its edges for one cycle. The strobes
// are valid in the cycle after the gate changes (gate vs. its registered copy).
//   clk    : system clock
//   reset  : synchronous, active-high reset (clears gate history)
//   gate_i : level-sensitive gate, synchronous to clk
//   rise_o : high for one cycle after a 0->1 gate change
//   fall_o : high for one cycle after a 1->0 gate change
// -----------------------------------------------------------------------------
module gate_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic gate_i,
    output logic rise_o,
    output logic fall_o
);
    logic gate_q;

    // gate history register
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate_i;
        end
    end

    assign rise_o = gate_i & ~gate_q;
    assign fall_o = ~gate_i & gate_q;
endmodule

// File: rtl/adsr_envelope_sequencer.sv
// -----------------------------------------------------------------------------
// adsr_envelope_sequencer
// Holds the envelope level and steps it through Attack/Decay/Sustain/Release
// from a note gate, commanding the exponential incrementer controller at each
// phase entry and consuming its inc_pulse step strobes.
//   clk   : system clock
//   reset : synchronous, active-high reset, overrides everything
//   bus   : adsr_envelope_sequencer_if.slave
//           in : gate, attack_len, decay_len, release_len, sustain_level,
//                inc_pulse
//           out: ctrl_start, ctrl_max_out, ctrl_pulse_length, level, phase,
//                active (all registered)
// Build option: ADSR_HARD_RETRIGGER_EN - a gate rise restarts ATTACK from
// level 0 instead of the current level (legato).
// -----------------------------------------------------------------------------
module adsr_envelope_sequencer
    import synth_env_pkg::*;
#(
    parameter int WIDTH         = 10,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    adsr_envelope_sequencer_if.slave  bus
);
    localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    localparam logic [WIDTH-1:0] MAXL        = WIDTH'(maxl(WIDTH));
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO        = WIDTH'(0);
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0]    SW_ONE      = SW'(1);
    localparam logic [SW-1:0]    SW_ZERO     = SW'(0);

    phase_e           phase_q, phase_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic             ctrl_start_q, ctrl_start_d;
    logic [WIDTH-1:0] ctrl_max_out_q, ctrl_max_out_d;
    logic [WIDTH-1:0] ctrl_pulse_length_q, ctrl_pulse_length_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             active_q;

    logic             gate_rise_s;
    logic             gate_fall_s;
    logic             pulse_ok_s;
    logic             enter_attack_s;
    logic             enter_decay_s;
    logic             enter_release_s;
    logic [WIDTH-1:0] attack_level_s;

    gate_edge_detect u_gate_edge (
        .clk    (clk),
        .reset  (reset),
        .gate_i (bus.gate),
        .rise_o (gate_rise_s),
        .fall_o (gate_fall_s)
    );

    // Starting level of a new ATTACK
`ifdef ADSR_HARD_RETRIGGER_EN
    assign attack_level_s = ZERO;
`else
    assign attack_level_s = level_q;
`endif

    // next-state: phase behaviour first, then phase-entry resolution
    always_comb begin
        phase_d             = phase_q;
        level_d             = level_q;
        ctrl_start_d        = 1'b0;
        ctrl_max_out_d      = ctrl_max_out_q;
        ctrl_pulse_length_d = ctrl_pulse_length_q;
        settle_d            = (settle_q != SW_ZERO) ? (settle_q - SW_ONE) : SW_ZERO;
        enter_attack_s      = 1'b0;
        enter_decay_s       = 1'b0;
        enter_release_s     = 1'b0;
        // Steps are blanked while the controller reloads its divider.
        pulse_ok_s          = bus.inc_pulse && (settle_q == SW_ZERO);

        // Gate edges take precedence; an inc_pulse in an edge cycle is dropped.
        case (phase_q)
            ST_IDLE: begin
                if (gate_rise_s) begin
                    enter_attack_s = 1'b1;
                end else begin
                    level_d = level_q;
                end
            end
            ST_ATTACK: begin
                if (gate_fall_s) begin
                    enter_release_s = 1'b1;
                end else if (pulse_ok_s) begin
                    if (level_q != MAXL) begin
                        level_d = level_q + ONE;
                    end else begin
                        level_d = MAXL;
                    end
                    enter_decay_s = (level_d == MAXL);
                end else begin
                    level_d = level_q;
                end
            end
            ST_DECAY: begin
                if (gate_fall_s) begin
                    enter_release_s = 1'b1;
                end else if (gate_rise_s) begin
                    enter_attack_s = 1'b1;
                end else if (pulse_ok_s) begin
                    if (level_q > bus.sustain_level) begin
                        level_d = level_q - ONE;
                    end else begin
                        level_d = level_q;
                    end
                    if (level_d <= bus.sustain_level) begin
                        phase_d = ST_SUSTAIN;
                    end else begin
                        phase_d = ST_DECAY;
                    end
                end else begin
                    level_d = level_q;
                end
            end
            ST_SUSTAIN: begin
                if (gate_fall_s) begin
                    enter_release_s = 1'b1;
                end else begin
                    level_d = bus.sustain_level;
                end
            end
            ST_RELEASE: begin
                if (gate_rise_s) begin
                    enter_attack_s = 1'b1;
                end else if (pulse_ok_s) begin
                    if (level_q != ZERO) begin
                        level_d = level_q - ONE;
                    end else begin
                        level_d = ZERO;
                    end
                    if (level_d == ZERO) begin
                        phase_d = ST_IDLE;
                    end else begin
                        phase_d = ST_RELEASE;
                    end
                end else begin
                    level_d = level_q;
                end
            end
            default: begin
                phase_d = ST_IDLE;
                level_d = ZERO;
            end
        endcase

        // Phase entry. A zero distance skips the phase without a controller
        // restart, since the controller would divide by zero.
        if (enter_release_s) begin
            if (level_d == ZERO) begin
                phase_d = ST_IDLE;
            end else begin
                phase_d             = ST_RELEASE;
                ctrl_start_d        = 1'b1;
                ctrl_max_out_d      = level_d;
                ctrl_pulse_length_d = bus.release_len;
                settle_d            = SETTLE_LOAD;
            end
        end else if (enter_attack_s && (attack_level_s != MAXL)) begin
            level_d             = attack_level_s;
            phase_d             = ST_ATTACK;
            ctrl_start_d        = 1'b1;
            ctrl_max_out_d      = MAXL - attack_level_s;
            ctrl_pulse_length_d = bus.attack_len;
            settle_d            = SETTLE_LOAD;
        end else if (enter_decay_s || enter_attack_s) begin
            // Reached from a finished ATTACK or a skipped one; level is MAXL.
            if (bus.sustain_level >= level_d) begin
                phase_d = ST_SUSTAIN;
            end else begin
                phase_d             = ST_DECAY;
                ctrl_start_d        = 1'b1;
                ctrl_max_out_d      = MAXL - bus.sustain_level;
                ctrl_pulse_length_d = bus.decay_len;
                settle_d            = SETTLE_LOAD;
            end
        end else begin
            ctrl_start_d = 1'b0;
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q             <= ST_IDLE;
            level_q             <= ZERO;
            ctrl_start_q        <= 1'b0;
            ctrl_max_out_q      <= ZERO;
            ctrl_pulse_length_q <= ZERO;
            settle_q            <= SW_ZERO;
            active_q            <= 1'b0;
        end else begin
            phase_q             <= phase_d;
            level_q             <= level_d;
            ctrl_start_q        <= ctrl_start_d;
            ctrl_max_out_q      <= ctrl_max_out_d;
            ctrl_pulse_length_q <= ctrl_pulse_length_d;
            settle_q            <= settle_d;
            active_q            <= (phase_d != ST_IDLE);
        end
    end

    assign bus.ctrl_start        = ctrl_start_q;
    assign bus.ctrl_max_out      = ctrl_max_out_q;
    assign bus.ctrl_pulse_length = ctrl_pulse_length_q;
    assign bus.level             = level_q;
    assign bus.phase             = phase_q;
    assign bus.active            = active_q;
endmodule

// File: tb/tb_adsr_envelope_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adsr_envelope_sequencer
// Self-checking bench for adsr_envelope_sequencer (WIDTH=10, SETTLE_CYCLES=4).
// A small controller model answers each ctrl_start with ctrl_max_out step
// pulses; expectations go into a scoreboard queue and are popped against
// the DUT outputs.
// -----------------------------------------------------------------------------
module tb_adsr_envelope_sequencer;
    localparam int W = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    adsr_envelope_sequencer_if #(.WIDTH(W)) bus_if ();

    adsr_envelope_sequencer #(.WIDTH(W), .SETTLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t sb[$];

    // controller model state
    logic inc_man     = 1'b0;
    logic model_pulse = 1'b0;
    bit   model_en    = 1'b0;
    int   rem         = 0;
    int   wait_c      = 0;

    assign bus_if.inc_pulse = inc_man | model_pulse;

    // controller model: 4 reload cycles after ctrl_start, then one step every other cycle
    always begin
        @(posedge clk); #1;
        if (reset) begin
            rem = 0; wait_c = 0; model_pulse = 1'b0;
        end else if (bus_if.ctrl_start) begin
            rem = int'(bus_if.ctrl_max_out); wait_c = 4; model_pulse = 1'b0;
        end else if (wait_c != 0) begin
            wait_c--; model_pulse = 1'b0;
        end else if (model_pulse) begin
            model_pulse = 1'b0;
        end else if (model_en && rem != 0) begin
            model_pulse = 1'b1; rem--;
        end else begin
            model_pulse = 1'b0;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int obs);
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_underflow", obs, -1);
        end else begin
            e = sb.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_phase(input int ph, input int budget, input string tag);
        int n = 0;
        push_exp(tag, ph);
        while (int'(bus_if.phase) != ph && n < budget) begin
            tick();
            n++;
        end
        pop_check(int'(bus_if.phase));
    endtask

    task automatic wait_level(input int lv, input int budget, input string tag);
        int n = 0;
        push_exp(tag, lv);
        while (int'(bus_if.level) != lv && n < budget) begin
            tick();
            n++;
        end
        pop_check(int'(bus_if.level));
    endtask

    task automatic expect_outputs(input string tag, input int ph, input int st, input int mx);
        push_exp({tag, "_phase"}, ph);
        push_exp({tag, "_start"}, st);
        push_exp({tag, "_max"}, mx);
        pop_check(int'(bus_if.phase));
        pop_check(int'(bus_if.ctrl_start));
        pop_check(int'(bus_if.ctrl_max_out));
    endtask

    initial begin
        int starts;
        int saw_decay;
        int n;

        bus_if.gate          = 1'b0;
        bus_if.attack_len    = 10'd5;
        bus_if.decay_len     = 10'd6;
        bus_if.release_len   = 10'd7;
        bus_if.sustain_level = 10'd512;

        // reset state
        tick(); tick();
        reset = 1'b0;
        push_exp("rst_level", 0);
        push_exp("rst_active", 0);
        push_exp("rst_plen", 0);
        pop_check(int'(bus_if.level));
        pop_check(int'(bus_if.active));
        pop_check(int'(bus_if.ctrl_pulse_length));
        expect_outputs("rst", 0, 0, 0);

        // 1: gate rise -> ATTACK with full distance
        model_en = 1'b1;
        bus_if.gate = 1'b1;
        tick();
        expect_outputs("att_entry", 1, 1, 1023);
        push_exp("att_plen", 5);
        push_exp("att_active", 1);
        pop_check(int'(bus_if.ctrl_pulse_length));
        pop_check(int'(bus_if.active));
        tick();
        push_exp("att_start_1cyc", 0);
        pop_check(int'(bus_if.ctrl_start));
        wait_phase(2, 3000, "to_decay");
        push_exp("att_top_level", 1023);
        push_exp("dec_plen", 6);
        pop_check(int'(bus_if.level));
        pop_check(int'(bus_if.ctrl_pulse_length));
        expect_outputs("dec_entry", 2, 1, 511);

        // 2: decay to sustain, extra pulses ignored, live sustain tracking
        wait_phase(3, 2000, "to_sustain");
        push_exp("sus_level", 512);
        pop_check(int'(bus_if.level));
        model_en = 1'b0;
        inc_man  = 1'b1;
        repeat (3) tick();
        inc_man  = 1'b0;
        push_exp("sus_hold", 512);
        pop_check(int'(bus_if.level));
        bus_if.sustain_level = 10'd600;
        tick();
        push_exp("sus_track", 600);
        pop_check(int'(bus_if.level));

        // gate fall in SUSTAIN -> RELEASE from 600
        model_en = 1'b1;
        bus_if.gate = 1'b0;
        tick();
        expect_outputs("rel_from_sus", 4, 1, 600);
        push_exp("rel_plen", 7);
        pop_check(int'(bus_if.ctrl_pulse_length));
        wait_phase(0, 3000, "rel_to_idle");
        push_exp("idle_level", 0);
        push_exp("idle_active", 0);
        pop_check(int'(bus_if.level));
        pop_check(int'(bus_if.active));

        // 3: gate falls mid-ATTACK at 700
        bus_if.gate = 1'b1;
        tick();
        expect_outputs("att2_entry", 1, 1, 1023);
        wait_level(700, 3000, "att2_700");
        bus_if.gate = 1'b0;
        tick();
        expect_outputs("rel700", 4, 1, 700);
        push_exp("rel700_level", 700);
        pop_check(int'(bus_if.level));
        wait_phase(0, 3000, "rel700_idle");
        push_exp("rel700_end_level", 0);
        push_exp("rel700_active", 0);
        pop_check(int'(bus_if.level));
        pop_check(int'(bus_if.active));

        // 4: pulses during the settle window are ignored, the 5th is taken
        model_en = 1'b0;
        bus_if.gate = 1'b1;
        tick();
        push_exp("settle_start", 1);
        pop_check(int'(bus_if.ctrl_start));
        inc_man = 1'b1;
        repeat (4) tick();
        push_exp("settle_ignored", 0);
        pop_check(int'(bus_if.level));
        tick();
        inc_man = 1'b0;
        push_exp("settle_accept", 1);
        pop_check(int'(bus_if.level));
        model_en = 1'b1;
        bus_if.gate = 1'b0;
        tick();
        expect_outputs("rel1", 4, 1, 1);
        wait_phase(0, 100, "rel1_idle");

        // 5: sustain at full scale skips DECAY without a second start
        bus_if.sustain_level = 10'd1023;
        bus_if.gate = 1'b1;
        tick();
        expect_outputs("att3_entry", 1, 1, 1023);
        starts = 0;
        saw_decay = 0;
        n = 0;
        while (int'(bus_if.phase) != 3 && n < 3000) begin
            tick();
            n++;
            if (bus_if.ctrl_start) starts++;
            if (int'(bus_if.phase) == 2) saw_decay = 1;
        end
        push_exp("skip_phase", 3);
        push_exp("skip_starts", 0);
        push_exp("skip_no_decay", 0);
        push_exp("skip_level", 1023);
        pop_check(int'(bus_if.phase));
        pop_check(starts);
        pop_check(saw_decay);
        pop_check(int'(bus_if.level));

        // re-rise during RELEASE at 300
        bus_if.gate = 1'b0;
        tick();
        expect_outputs("rel_full", 4, 1, 1023);
        wait_level(300, 3000, "rel_300");
        bus_if.gate = 1'b1;
        tick();
`ifdef ADSR_HARD_RETRIGGER_EN
        expect_outputs("retrig", 1, 1, 1023);
        push_exp("retrig_level", 0);
`else
        expect_outputs("legato", 1, 1, 723);
        push_exp("legato_level", 300);
`endif
        pop_check(int'(bus_if.level));

        // 6: reset mid-ATTACK at 400 with a coincident pulse
        wait_level(400, 2000, "att_400");
        reset   = 1'b1;
        inc_man = 1'b1;
        bus_if.gate = 1'b0;
        tick();
        push_exp("mid_rst_level", 0);
        push_exp("mid_rst_active", 0);
        push_exp("mid_rst_plen", 0);
        pop_check(int'(bus_if.level));
        pop_check(int'(bus_if.active));
        pop_check(int'(bus_if.ctrl_pulse_length));
        expect_outputs("mid_rst", 0, 0, 0);
        reset   = 1'b0;
        inc_man = 1'b0;
        tick();
        push_exp("post_rst_level", 0);
        pop_check(int'(bus_if.level));

        check_val("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adsr_envelope_sequencer.md
Name: adsr_envelope_sequencer

Overview:
- Downstream consumer of the approximately-exponential incrementer controller's `inc_control` pulse stream.
- Holds the envelope level register and sequences Attack/Decay/Sustain/Release phases from a note gate.
- Drives the controller's `start`, `max_out` and `pulse_length` inputs for each phase.
- Its `level` output feeds the VCA/VCF modulation path.

Parameters:
- WIDTH, 10, bit width of level, phase lengths, sustain and controller operands.
- SETTLE_CYCLES, 4, cycles after `ctrl_start` during which `inc_pulse` is ignored while the controller reloads its divider (controller needs 3).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- gate  in  1  note gate, level-sensitive, synchronous to clk
- attack_len  in  WIDTH  attack duration code, passed to controller
- decay_len  in  WIDTH  decay duration code
- release_len  in  WIDTH  release duration code
- sustain_level  in  WIDTH  sustain target level
- inc_pulse  in  1  step strobe from the controller's `inc_control`
- ctrl_start  out  1  one-cycle restart strobe to the controller
- ctrl_max_out  out  WIDTH  step count for the current phase
- ctrl_pulse_length  out  WIDTH  duration code for the current phase
- level  out  WIDTH  envelope level
- phase  out  3  0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
- active  out  1  high whenever phase != IDLE

Behaviour:
- Clocking and reset: single clock. Reset is synchronous, active-high, and wins over everything.
- Reset values: phase=IDLE, level=0, ctrl_start=0, ctrl_max_out=0, ctrl_pulse_length=0, active=0, settle counter=0, gate history=0.
- Gate edges: rise/fall are detected against a registered copy of gate. An edge is acted on in the cycle after gate changes.
- Phase entry (ATTACK, DECAY, RELEASE):
  - Registers ctrl_max_out = distance to target and ctrl_pulse_length = the phase's *_len.
  - Pulses ctrl_start for exactly 1 cycle and loads settle counter = SETTLE_CYCLES.
  - inc_pulse is ignored while settle counter != 0.
  - Distance: ATTACK = MAXL - level, where MAXL = 2^WIDTH-1. DECAY = MAXL - sustain_level. RELEASE = level at entry.
- Zero distance: if the computed distance is 0, the phase is skipped in the same cycle, with no ctrl_start. This avoids a controller divide-by-zero.
  - ATTACK with 0 distance -> DECAY.
  - DECAY with 0 distance -> SUSTAIN.
  - RELEASE with 0 distance -> IDLE.
- IDLE: gate rise -> ATTACK.
- ATTACK: each accepted inc_pulse does level+1. The step that reaches MAXL moves to DECAY (entry rules apply). Level saturates and never wraps.
- DECAY: each accepted inc_pulse does level-1. At level == sustain_level -> SUSTAIN. If sustain_level >= level on entry, go straight to SUSTAIN.
- SUSTAIN: level holds at sustain_level. Live changes to sustain_level are tracked each cycle. No ctrl_start is issued.
- RELEASE: each accepted inc_pulse does level-1. At 0 -> IDLE. Level never underflows.
- Gate fall in ATTACK, DECAY or SUSTAIN -> RELEASE from the current level.
- Gate rise in RELEASE or DECAY -> ATTACK from the current level (legato).
- Priority in one cycle: reset > gate edge > inc_pulse. An inc_pulse coinciding with a phase change is discarded.
- Latency: from an accepted inc_pulse to the updated level is 1 cycle.
- Length inputs are sampled only at phase entry. Mid-phase changes take effect at the next entry.

Optional Feature:
- Macro: ADSR_HARD_RETRIGGER_EN.
- Defined: a gate rise in any non-IDLE phase forces level=0 in the same cycle it enters ATTACK, so ATTACK distance = MAXL.
- Undefined: legato behaviour as above, where ATTACK starts from the current level.

Decomposition:
- Shared package `synth_env_pkg` holds:
  - phase encoding localparams PH_IDLE..PH_RELEASE
  - the MAXL function of WIDTH
  - the default SETTLE_CYCLES
- One natural sub-module: `gate_edge_detect`, which registers gate and emits one-cycle rise/fall strobes. It is reusable by the LFO sync logic.

Test Plan (WIDTH=10, SETTLE_CYCLES=4, inc_pulse driven by a bench model):
1. Reset, then gate rises:
   - ctrl_start=1 one cycle later with ctrl_max_out=1023 and ctrl_pulse_length=attack_len.
   - After 1023 accepted pulses, level=1023 and phase=DECAY.
   - A second ctrl_start follows with max_out=1023-sustain.
2. sustain_level=512, gate held:
   - Level decays to 512 and phase=SUSTAIN.
   - Extra inc_pulses leave level at 512.
   - Changing sustain_level to 600 gives level=600 next cycle.
3. Gate falls at level=700 in ATTACK:
   - phase=RELEASE, ctrl_max_out=700, ctrl_start pulsed.
   - 700 pulses later level=0, phase=IDLE, active=0.
4. inc_pulse asserted on the cycle of ctrl_start and the next 3 cycles:
   - Level is unchanged.
   - The 5th-cycle pulse is accepted.
5. sustain_level=1023:
   - DECAY is skipped and phase goes ATTACK->SUSTAIN with no second ctrl_start.
   - Gate re-rise during RELEASE at level=300: legato build gives ctrl_max_out=723; with ADSR_HARD_RETRIGGER_EN, level=0 and max_out=1023.
6. reset asserted mid-ATTACK at level=400:
   - Next cycle level=0, phase=IDLE, all outputs 0.
   - A simultaneous inc_pulse has no effect.
